// File: rtl/seq_booth_mult.sv
// seq_booth_mult: radix-2 Booth sequential multiplier, one step per cycle,
// valid/ready on both sides.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (in_ready high only when idle)
//   a, b                 multiplicand / multiplier, WIDTH bits
//   out_valid, out_ready result handshake (out_valid high only when done)
//   product              registered a*b, 2*WIDTH bits, held until next result
//
// Parameters: WIDTH (4..64), SIGNED (1 = two's complement, 0 = unsigned).
module seq_booth_mult #(
   parameter int WIDTH  = 25,
   parameter int SIGNED = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int N  = (SIGNED != 0) ? WIDTH : WIDTH + 1;
   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [WIDTH:0] acc;
   logic [WIDTH:0] q;
   logic [WIDTH:0] m;
   logic           q_m1;
   logic [CW-1:0]  cnt;

   logic [WIDTH:0]       a_ext;
   logic [WIDTH:0]       b_ext;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   prod_nx;
   logic                 capture;
   logic                 step;
   logic                 last;

   assign a_ext = (SIGNED != 0) ? {a[WIDTH-1], a} : {1'b0, a};
   assign b_ext = (SIGNED != 0) ? {b[WIDTH-1], b} : {1'b0, b};
   assign last  = (cnt == LAST);

   // One extra bit of headroom makes -2^(WIDTH-1) exact.
   always_comb begin
      sum = acc;
      unique case ({q[0], q_m1})
         2'b01:   sum = acc + m;
         2'b10:   sum = acc - m;
         default: sum = acc;
      endcase
   end

   // Product as it will stand after this step's shift. In signed mode
   // only WIDTH steps run, so the unexamined sign copy still sits in
   // the bottom bit and the result is taken one position higher.
   always_comb begin
      if (SIGNED != 0)
         prod_nx = {sum, q[WIDTH:2]};
      else
         prod_nx = {sum[WIDTH-1:0], q[WIDTH:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      capture   = 1'b0;
      step      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               capture  = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last)
               state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         q       <= '0;
         m       <= '0;
         q_m1    <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else if (capture) begin
         acc  <= '0;
         q    <= b_ext;
         m    <= a_ext;
         q_m1 <= 1'b0;
         cnt  <= '0;
      end else if (step) begin
         acc  <= {sum[WIDTH], sum[WIDTH:1]};
         q    <= {sum[0], q[WIDTH:1]};
         q_m1 <= q[0];
         cnt  <= cnt + 1'b1;
         if (last)
            product <= prod_nx;
      end
   end

endmodule

// File: tb/tb_seq_booth_mult.sv
// tb_seq_booth_mult: directed 8-bit checks (signed/unsigned, backpressure,
// reset) and a scoreboarded random run on the default 25-bit signed build.
module tb_seq_booth_mult;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic        s_iv, s_ir, s_ov, s_or;
   logic [7:0]  s_a, s_b;
   logic [15:0] s_p;

   logic        u_iv, u_ir, u_ov, u_or;
   logic [7:0]  u_a, u_b;
   logic [15:0] u_p;

   logic        w_iv, w_ir, w_ov, w_or;
   logic [24:0] w_a, w_b;
   logic [49:0] w_p;

   logic [49:0] exp_q[$];
   logic [24:0] op_a[$];
   logic [24:0] op_b[$];

   seq_booth_mult #(.WIDTH(8), .SIGNED(1)) u_s8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_iv), .in_ready(s_ir), .a(s_a), .b(s_b),
      .out_valid(s_ov), .out_ready(s_or), .product(s_p)
   );

   seq_booth_mult #(.WIDTH(8), .SIGNED(0)) u_u8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(u_iv), .in_ready(u_ir), .a(u_a), .b(u_b),
      .out_valid(u_ov), .out_ready(u_or), .product(u_p)
   );

   seq_booth_mult u_w25 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(w_iv), .in_ready(w_ir), .a(w_a), .b(w_b),
      .out_valid(w_ov), .out_ready(w_or), .product(w_p)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [49:0] ref25(input logic [24:0] x,
                                         input logic [24:0] y);
      longint sx, sy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p  = sx * sy;
      return p[49:0];
   endfunction

   // Wait for out_valid on the signed 8-bit instance, counting cycles
   // from the capture edge.
   task automatic wait_s(input string tag, input logic [15:0] exp);
      int lat;
      lat = 0;
      while (!s_ov && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'd9);
      chk({tag, "_prod"}, 64'(s_p), 64'(exp));
   endtask

   task automatic run_s(input string tag, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] exp);
      @(negedge clk);
      chk({tag, "_ir"}, 64'(s_ir), 64'd1);
      s_a = x;
      s_b = y;
      s_iv = 1'b1;
      @(posedge clk);
      #1 s_iv = 1'b0;
      wait_s(tag, exp);
      s_or = 1'b1;
      @(posedge clk);
      #1 s_or = 1'b0;
      chk({tag, "_ov_clr"}, 64'(s_ov), 64'd0);
      chk({tag, "_ir_back"}, 64'(s_ir), 64'd1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int lat, sent, recv, cyc, total;
      bit pend;
      logic [24:0] corner [5];

      s_iv = 0; s_or = 0; s_a = 0; s_b = 0;
      u_iv = 0; u_or = 0; u_a = 0; u_b = 0;
      w_iv = 0; w_or = 0; w_a = 0; w_b = 0;

      // in_valid during reset must not be captured
      s_iv = 1'b1;
      s_a = 8'h03;
      s_b = 8'h03;
      repeat (3) @(posedge clk);
      @(negedge clk);
      s_iv = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("rst_s_ir", 64'(s_ir), 64'd1);
      chk("rst_s_ov", 64'(s_ov), 64'd0);
      chk("rst_s_p", 64'(s_p), 64'd0);
      chk("rst_u_ir", 64'(u_ir), 64'd1);
      chk("rst_u_ov", 64'(u_ov), 64'd0);
      chk("rst_u_p", 64'(u_p), 64'd0);
      chk("rst_w_ir", 64'(w_ir), 64'd1);
      chk("rst_w_ov", 64'(w_ov), 64'd0);
      chk("rst_w_p", 64'(w_p), 64'd0);

      run_s("s5xm3", 8'h05, 8'hFD, 16'hFFF1);
      run_s("sminmin", 8'h80, 8'h80, 16'h4000);
      run_s("sminmax", 8'h80, 8'h7F, 16'hC080);
      run_s("sm1m1", 8'hFF, 8'hFF, 16'h0001);

      // unsigned 8-bit: one extra step
      @(negedge clk);
      u_a = 8'hFF;
      u_b = 8'hFF;
      u_iv = 1'b1;
      @(posedge clk);
      #1 u_iv = 1'b0;
      lat = 0;
      while (!u_ov && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("uffff_lat", 64'(lat), 64'd10);
      chk("uffff_prod", 64'(u_p), 64'h0000_FE01);
      u_or = 1'b1;
      @(posedge clk);
      #1 u_or = 1'b0;
      chk("uffff_ir", 64'(u_ir), 64'd1);

      // backpressure with new operands offered while DONE
      @(negedge clk);
      s_a = 8'h07;
      s_b = 8'h06;
      s_iv = 1'b1;
      @(posedge clk);
      #1 s_iv = 1'b0;
      wait_s("bp", 16'h002A);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         s_iv = i[0];
         s_a = 8'h11;
         s_b = 8'h22;
         #1;
         chk("bp_hold_p", 64'(s_p), 64'h2A);
         chk("bp_hold_ov", 64'(s_ov), 64'd1);
         chk("bp_hold_ir", 64'(s_ir), 64'd0);
      end
      @(negedge clk);
      s_a = 8'h03;
      s_b = 8'h03;
      s_iv = 1'b1;
      s_or = 1'b1;
      @(posedge clk);
      #1 s_or = 1'b0;
      chk("bp_rel_ir", 64'(s_ir), 64'd1);
      chk("bp_rel_ov", 64'(s_ov), 64'd0);
      chk("bp_rel_p", 64'(s_p), 64'h2A);
      @(posedge clk);
      #1 s_iv = 1'b0;
      chk("bp_cap_ir", 64'(s_ir), 64'd0);
      wait_s("bp_next", 16'h0009);
      s_or = 1'b1;
      @(posedge clk);
      #1 s_or = 1'b0;

      // reset in the middle of a run
      @(negedge clk);
      s_a = 8'h7F;
      s_b = 8'h7F;
      s_iv = 1'b1;
      @(posedge clk);
      #1 s_iv = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", 64'(s_ov), 64'd0);
      chk("mid_rst_p", 64'(s_p), 64'd0);
      chk("mid_rst_up", 64'(u_p), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_ir", 64'(s_ir), 64'd1);
      repeat (12) @(posedge clk);
      #1 chk("mid_rst_noout", 64'(s_ov), 64'd0);
      run_s("s3x4", 8'h03, 8'h04, 16'h000C);

      // 25-bit scoreboard run: corners then random pairs
      corner[0] = 25'h0000000;
      corner[1] = 25'h0000001;
      corner[2] = 25'h1FFFFFF;
      corner[3] = 25'h0FFFFFF;
      corner[4] = 25'h1000000;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            op_a.push_back(corner[i]);
            op_b.push_back(corner[j]);
         end
      for (int i = 0; i < 1500; i++) begin
         op_a.push_back(25'($urandom));
         op_b.push_back(25'($urandom));
      end
      total = op_a.size();
      sent = 0;
      recv = 0;
      cyc = 0;
      pend = 1'b0;
      while (recv < total && cyc < 80000) begin
         @(negedge clk);
         cyc++;
         w_or = ($urandom_range(0, 3) != 0);
         if (w_ov && w_or) begin
            if (exp_q.size() == 0)
               chk("w_dup", 64'd1, 64'd0);
            else
               chk("w_prod", 64'(w_p), 64'(exp_q.pop_front()));
            recv++;
         end
         if (pend) begin
            w_iv = 1'b0;
            pend = 1'b0;
         end
         if (!w_iv && sent < total && $urandom_range(0, 2) != 0) begin
            w_a = op_a[sent];
            w_b = op_b[sent];
            w_iv = 1'b1;
         end
         if (w_iv && w_ir) begin
            exp_q.push_back(ref25(w_a, w_b));
            sent++;
            pend = 1'b1;
         end
      end
      w_iv = 1'b0;
      w_or = 1'b0;
      chk("w_count", 64'(recv), 64'(total));
      chk("w_left", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
